// File: rtl/la32r_pkg.sv
// LA32R opcode constants and the pre-decode helper shared by the
// instruction queue and anything else that classifies fetched words.
package la32r_pkg;

  localparam logic [5:0] OP_LDST  = 6'b001010;
  localparam logic [5:0] OP_JIRL  = 6'b010011;
  localparam logic [5:0] OP_B     = 6'b010100;
  localparam logic [5:0] OP_BL    = 6'b010101;
  localparam logic [5:0] OP_BR_LO = 6'b010110;
  localparam logic [5:0] OP_BR_HI = 6'b011011;

  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       rf_we;
    logic [4:0] ra0;
    logic [4:0] ra1;
    logic [4:0] wa;
  } dec_t;

  function automatic dec_t predecode(input logic [31:0] inst);
    dec_t       d;
    logic [5:0] op;
    logic       is_st;
    logic       is_ld;
    logic       is_cbr;
    op     = inst[31:26];
    is_st  = (op == OP_LDST) && !inst[25] && inst[24];
    is_ld  = (op == OP_LDST) && (inst[25] || !inst[24]);
    is_cbr = (op >= OP_BR_LO) && (op <= OP_BR_HI);
    d.is_load   = is_ld;
    d.is_store  = is_st;
    d.is_branch = (inst[31:30] == 2'b01);
    // Stores and conditional branches read their rd field as a source.
    d.rf_we     = (op == OP_JIRL) || !(is_st || (op == OP_B) || is_cbr);
    d.ra0       = inst[9:5];
    d.ra1       = (is_st || is_cbr) ? inst[4:0] : inst[14:10];
    d.wa        = (op == OP_BL) ? 5'd1 : inst[4:0];
    return d;
  endfunction

endpackage

// File: rtl/inst_queue_dec_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
interface inst_queue_dec_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_is_load;
  logic              out_is_store;
  logic              out_is_branch;
  logic [4:0]        out_rf_ra0;
  logic [4:0]        out_rf_ra1;
  logic [4:0]        out_rf_wa;
  logic              out_rf_we;
  logic              haz_ld_valid;
  logic [4:0]        haz_ld_rd;

  modport master (
    output in_valid, in_pc, in_inst, out_ready, haz_ld_valid, haz_ld_rd,
    input  in_ready, out_valid, out_pc, out_inst, out_is_load, out_is_store,
           out_is_branch, out_rf_ra0, out_rf_ra1, out_rf_wa, out_rf_we
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready, haz_ld_valid, haz_ld_rd,
    output in_ready, out_valid, out_pc, out_inst, out_is_load, out_is_store,
           out_is_branch, out_rf_ra0, out_rf_ra1, out_rf_wa, out_rf_we
  );
endinterface

// File: rtl/inst_fifo.sv
// Circular buffer with occupancy count; storage is deliberately left
// unreset, only pointers and count return to zero on reset or flush.
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= wdata;
  end

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign rdata = mem[head];

endmodule

// File: rtl/inst_queue_dec.sv
// Fetch-to-decode instruction queue: buffers fetched words, holds back a
// load-use dependent head, and pre-decodes into a registered output stage.
module inst_queue_dec
  import la32r_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  inst_queue_dec_if.slave        bus,
  output logic [$clog2(DEPTH):0] count
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PC_W+INST_W-1:0] head_ent;
  logic [PC_W-1:0]        head_pc;
  logic [INST_W-1:0]      head_inst;
  dec_t                   head_dec;
  logic                   push;
  logic                   pop;
  logic                   hazard;

  logic                   vld_p1;
  logic [PC_W-1:0]        pc_p1;
  logic [INST_W-1:0]      inst_p1;
  dec_t                   dec_p1;

  // Stage p0: queue head, hazard detection against the load in EX
  assign bus.in_ready = (count < CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready && !flush;
  assign {head_pc, head_inst} = head_ent;
  assign head_dec     = predecode(head_inst);
  assign hazard       = bus.haz_ld_valid && (bus.haz_ld_rd != 5'd0) &&
                        ((bus.haz_ld_rd == head_dec.ra0) || (bus.haz_ld_rd == head_dec.ra1));
  assign pop          = (count != '0) && (!vld_p1 || bus.out_ready) && !hazard && !flush;

  inst_fifo #(
    .DEPTH (DEPTH),
    .W     (PC_W + INST_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.in_pc, bus.in_inst}),
    .rdata (head_ent),
    .count (count)
  );

  // Stage p1: registered issue slot toward decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      pc_p1   <= '0;
      inst_p1 <= '0;
      dec_p1  <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
    end else if (pop) begin
      vld_p1  <= 1'b1;
      pc_p1   <= head_pc;
      inst_p1 <= head_inst;
      dec_p1  <= head_dec;
    end else if (bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.out_valid     = vld_p1;
  assign bus.out_pc        = pc_p1;
  assign bus.out_inst      = inst_p1;
  assign bus.out_is_load   = dec_p1.is_load;
  assign bus.out_is_store  = dec_p1.is_store;
  assign bus.out_is_branch = dec_p1.is_branch;
  assign bus.out_rf_ra0    = dec_p1.ra0;
  assign bus.out_rf_ra1    = dec_p1.ra1;
  assign bus.out_rf_wa     = dec_p1.wa;
  assign bus.out_rf_we     = dec_p1.rf_we;

endmodule

// File: tb/tb_inst_queue_dec.sv
// Bench for inst_queue_dec: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_inst_queue_dec;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [$clog2(DEPTH):0] count;
  int n_checks = 0;
  int n_errors = 0;

  inst_queue_dec_if #(.PC_W(32), .INST_W(32)) bus ();

  inst_queue_dec #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference classification by instruction kind
  typedef struct packed {
    logic ld; logic st; logic br; logic we;
    logic [4:0] ra0; logic [4:0] ra1; logic [4:0] wa;
  } ref_t;

  function automatic ref_t ref_dec(input logic [31:0] i);
    ref_t r;
    int kind;  // 0 alu, 1 load, 2 store, 3 b, 4 bl, 5 jirl, 6 cond branch
    case (i[31:26])
      6'b001010: kind = (i[25:24] == 2'b01) ? 2 : 1;
      6'b010011: kind = 5;
      6'b010100: kind = 3;
      6'b010101: kind = 4;
      6'b010110, 6'b010111, 6'b011000,
      6'b011001, 6'b011010, 6'b011011: kind = 6;
      default:   kind = 0;
    endcase
    r.ld  = (kind == 1);
    r.st  = (kind == 2);
    r.br  = (i[31:30] == 2'b01);
    r.we  = !(kind == 2 || kind == 3 || kind == 6);
    r.ra0 = i[9:5];
    r.ra1 = (kind == 2 || kind == 6) ? i[4:0] : i[14:10];
    r.wa  = (kind == 4) ? 5'd1 : i[4:0];
    return r;
  endfunction

  function automatic logic [18:0] dut_dec();
    return {bus.out_is_load, bus.out_is_store, bus.out_is_branch, bus.out_rf_we,
            bus.out_rf_ra0, bus.out_rf_ra1, bus.out_rf_wa};
  endfunction

  function automatic bit ref_haz(input logic [31:0] inst);
    ref_t r;
    r = ref_dec(inst);
    return bus.haz_ld_valid && (bus.haz_ld_rd != 5'd0) &&
           (bus.haz_ld_rd == r.ra0 || bus.haz_ld_rd == r.ra1);
  endfunction

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t mq[$];
  ent_t m_out;
  bit   m_vld = 1'b0;
  bit   m_push;

  // Model advances on each edge from the inputs, then outputs are compared
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_vld = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_vld = 1'b0;
    end else begin
      m_push = bus.in_valid && (mq.size() < DEPTH);
      if (mq.size() > 0 && (!m_vld || bus.out_ready) && !ref_haz(mq[0].inst)) begin
        m_out = mq.pop_front();
        m_vld = 1'b1;
      end else if (m_vld && bus.out_ready) begin
        m_vld = 1'b0;
      end
      if (m_push) mq.push_back('{pc: bus.in_pc, inst: bus.in_inst});
    end
    #2;
    check("m_out_valid", 32'(bus.out_valid), 32'(m_vld));
    check("m_count", 32'(count), mq.size());
    check("m_in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
    if (m_vld) begin
      check("m_out_pc", bus.out_pc, m_out.pc);
      check("m_out_inst", bus.out_inst, m_out.inst);
      check("m_predecode", 32'(dut_dec()), 32'(ref_dec(m_out.inst)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_inst  = inst;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  logic [31:0] tbl [7] = '{32'h29800005, 32'h54000000, 32'h58000022, 32'h288000E6,
                           32'h50000000, 32'h4C000021, 32'h00101043};
  logic [18:0] exp_dec [7] = '{{4'b0100, 5'd0, 5'd5, 5'd5},
                               {4'b0011, 5'd0, 5'd0, 5'd1},
                               {4'b0010, 5'd1, 5'd2, 5'd2},
                               {4'b1001, 5'd7, 5'd0, 5'd6},
                               {4'b0010, 5'd0, 5'd0, 5'd0},
                               {4'b0011, 5'd1, 5'd0, 5'd1},
                               {4'b0001, 5'd2, 5'd4, 5'd3}};
  localparam logic [31:0] BASE = 32'h1c000000;

  initial begin
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0;
    bus.out_ready = 1'b0; bus.haz_ld_valid = 1'b0; bus.haz_ld_rd = '0;
    tick(); tick();
    check("rst_count", 32'(count), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_pc", bus.out_pc, 0);
    check("rst_out_inst", bus.out_inst, 0);
    check("rst_predecode", 32'(dut_dec()), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    rst_n = 1'b1;

    // Fill with the output slot occupied and decode stalled
    push(32'h100, 32'h00101043); tick();
    idle(); tick();
    check("fill_held_valid", 32'(bus.out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      push(32'h200 + 32'(4 * k), 32'h00100000 | 32'(k));
      tick();
      if (k == 3) begin
        check("fill_count4", 32'(count), 4);
        check("fill_in_ready0", 32'(bus.in_ready), 0);
      end
      if (k == 4) begin
        check("fill_5th_rejected", 32'(count), 4);
        check("fill_out_stable", bus.out_pc, 32'h100);
      end
    end
    idle(); bus.out_ready = 1'b1;
    tick();
    check("drain_first", bus.out_pc, 32'h200);
    repeat (6) tick();
    check("drain_empty", 32'(count), 0);
    check("drain_bubble", 32'(bus.out_valid), 0);

    // Back-to-back streaming
    for (int k = 0; k < 8; k++) begin
      if (k < 6) push(BASE + 32'(4 * k), 32'h02800000 | 32'(k));
      else idle();
      tick();
      if (k == 0) check("stream_latency", 32'(bus.out_valid), 0);
      if (k >= 1 && k <= 6) begin
        check("stream_pc", bus.out_pc, BASE + 32'(4 * (k - 1)));
        check("stream_valid", 32'(bus.out_valid), 1);
      end
      if (k <= 5) check("stream_count", 32'(count), 1);
    end

    // Load-use stall on ra1 = r4
    bus.haz_ld_valid = 1'b1; bus.haz_ld_rd = 5'd4;
    push(BASE + 32'h1000, 32'h00101043); tick();
    idle(); tick();
    check("ldu_stall_valid", 32'(bus.out_valid), 0);
    check("ldu_stall_count", 32'(count), 1);
    tick();
    check("ldu_stall_valid2", 32'(bus.out_valid), 0);
    bus.haz_ld_valid = 1'b0; tick();
    check("ldu_release", 32'(bus.out_valid), 1);
    check("ldu_release_inst", bus.out_inst, 32'h00101043);
    tick();
    bus.haz_ld_valid = 1'b1; bus.haz_ld_rd = 5'd0;
    push(BASE + 32'h1004, 32'h00101043); tick();
    idle(); tick();
    check("ldu_r0_no_stall", bus.out_pc, BASE + 32'h1004);
    bus.haz_ld_valid = 1'b0; tick();

    // Flush with a full output slot and a concurrent push
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push(32'h300 + 32'(4 * k), 32'h02800000); tick();
    end
    check("pre_flush_count", 32'(count), 3);
    check("pre_flush_valid", 32'(bus.out_valid), 1);
    flush = 1'b1; push(32'h400, 32'h02800000); tick();
    check("flush_count", 32'(count), 0);
    check("flush_valid", 32'(bus.out_valid), 0);
    flush = 1'b0; idle(); bus.out_ready = 1'b1;
    repeat (3) begin
      tick();
      check("post_flush_idle", 32'(bus.out_valid), 0);
    end

    // Pre-decode table
    for (int k = 0; k < 8; k++) begin
      if (k < 7) push(32'h500 + 32'(4 * k), tbl[k]);
      else idle();
      tick();
      if (k >= 1) begin
        check("dec_inst", bus.out_inst, tbl[k - 1]);
        check("dec_fields", 32'(dut_dec()), 32'(exp_dec[k - 1]));
      end
    end
    tick();

    // Reset asserted with traffic in flight
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push(32'h600 + 32'(4 * k), 32'h02800000); tick();
    end
    idle();
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 0);
    check("async_rst_valid", 32'(bus.out_valid), 0);
    check("async_rst_pc", bus.out_pc, 0);
    tick();
    #3 rst_n = 1'b1;
    push(32'h700, 32'h00101043); tick();
    check("post_rst_push", 32'(count), 1);
    idle(); tick();
    check("post_rst_issue", bus.out_pc, 32'h700);

    // Mixed stall / hazard / flush traffic against the model
    for (int i = 0; i < 300; i++) begin
      bus.in_valid     = (i % 3) != 2;
      bus.in_pc        = 32'h800 + 32'(4 * i);
      bus.in_inst      = tbl[i % 7];
      bus.out_ready    = (i % 5) != 0;
      bus.haz_ld_valid = (i % 4) == 1;
      bus.haz_ld_rd    = 5'(i % 8);
      flush            = (i % 41) == 40;
      tick();
    end
    flush = 1'b0; idle(); bus.out_ready = 1'b1; bus.haz_ld_valid = 1'b0;
    repeat (10) tick();
    check("final_empty", 32'(count), 0);

    #3;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
